// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, encodings and fetch FSM states for the pipeline
package pipeline_pkg;

    localparam int PC_W = 16;
    localparam int INSTR_W = 16;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - single-entry data+valid capture with load and clear
module fetch_skid_buffer #(
    parameter int WIDTH = pipeline_pkg::INSTR_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // clear beats load so a redirect always discards a captured word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= load_valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, in-flight fetch tracking, stall/redirect FSM and IF/ID register
module fetch_stage #(
    parameter int                 PC_W      = pipeline_pkg::PC_W,
    parameter int                 INSTR_W   = pipeline_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC  = pipeline_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid
);

    import pipeline_pkg::*;

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    pend_pc;
    logic               pend_valid;
    logic [INSTR_W-1:0] skid_data;
    logic               skid_valid;
    logic               do_redirect;
    logic               do_capture;
    logic               do_advance;
    logic               src_valid;
    logic [INSTR_W-1:0] src_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        do_redirect = 1'b0;
        do_capture  = 1'b0;
        do_advance  = 1'b0;
        if (redirect) begin
            do_redirect = 1'b1;
            state_next  = RUN;
        end else if (stall) begin
            // memory keeps reading fetch_pc while stalled, so the pend_pc word is only on rdata now
            do_capture  = (state == RUN);
            state_next  = STALL;
        end else begin
            do_advance  = 1'b1;
            state_next  = RUN;
        end
    end

    assign src_valid = (state == STALL) ? skid_valid : pend_valid;
    assign src_data  = (state == STALL) ? skid_data  : imem_rdata;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            pend_pc     <= '0;
            pend_valid  <= 1'b0;
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else if (do_redirect) begin
            fetch_pc    <= redirect_pc;
            pend_valid  <= 1'b0;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (do_advance) begin
            instruction <= src_valid ? src_data : NOP_INSTR;
            instr_valid <= src_valid;
            pc_out      <= pend_pc;
            pend_pc     <= fetch_pc;
            pend_valid  <= 1'b1;
            fetch_pc    <= fetch_pc + 1'b1;
        end
    end

    fetch_skid_buffer #(
        .WIDTH(INSTR_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (do_capture),
        .clear     (do_redirect),
        .load_data (imem_rdata),
        .load_valid(pend_valid),
        .data      (skid_data),
        .valid     (skid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a program-order reference model
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instruction;
    logic [15:0] pc_out;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_out;
    logic [15:0] m_next_pc;
    int          m_bubbles;

    fetch_stage dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instruction(instruction),
        .pc_out     (pc_out),
        .instr_valid(instr_valid)
    );

    always #5 clock = ~clock;

    // ROM: mem[i] = 16'h1000 + i, one-cycle synchronous read
    always @(posedge clock) imem_rdata <= 16'h1000 + imem_addr;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: outputs follow program order; one bubble after reset or redirect, stalls freeze outputs
    task automatic model_reset();
        m_out     = '0;
        m_next_pc = 16'h0000;
        m_bubbles = 1;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [15:0] rpc);
        if (r) begin
            m_out.valid = 1'b0;
            m_out.instr = 16'h0000;
            m_next_pc   = rpc;
            m_bubbles   = 1;
        end else if (!s) begin
            if (m_bubbles > 0) begin
                m_out.valid = 1'b0;
                m_out.instr = 16'h0000;
                m_bubbles--;
            end else begin
                m_out.valid = 1'b1;
                m_out.instr = 16'h1000 + m_next_pc;
                m_out.pc    = m_next_pc;
                m_next_pc   = m_next_pc + 16'h0001;
            end
        end
        exp_q.push_back(m_out);
    endtask

    task automatic step(input logic s, input logic r, input logic [15:0] rpc);
        @(negedge clock);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        model_step(s, r, rpc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, instruction, 16'h0000);
        check({tag, "_pc"}, pc_out, 16'h0000);
        check({tag, "_valid"}, {15'b0, instr_valid}, 16'h0000);
    endtask

    // asynchronous pulse between edges; outputs must clear before the next edge
    task automatic reset_pulse();
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        #1 reset_n = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        model_reset();
        model_step(1'b0, 1'b0, 16'h0000);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("instr_valid", {15'b0, instr_valid}, {15'b0, e.valid});
                check("instruction", instruction, e.instr);
                if (e.valid) check("pc_out", pc_out, e.pc);
            end
        end
    end

    initial begin : driver
        int unsigned rnd;
        logic [15:0] rpc;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        model_reset();
        model_step(1'b0, 1'b0, 16'h0000);

        repeat (4) step(1'b0, 1'b0, 16'h0000);
        repeat (3) step(1'b1, 1'b0, 16'h0000);
        repeat (4) step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0040);
        repeat (4) step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h0040);
        repeat (4) step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'hFFFE);
        repeat (6) step(1'b0, 1'b0, 16'h0000);
        repeat (3) step(1'b1, 1'b0, 16'h0000);
        reset_pulse();
        repeat (7) step(1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            rpc = rnd[20] ? (16'hFFF8 + {12'h000, rnd[27:24]}) : rnd[31:16];
            if (rnd[7:0] < 8'd3) reset_pulse();
            else step(rnd[9:8] == 2'b11 || rnd[10], rnd[15:11] < 5'd3, rpc);
        end

        @(posedge clock);
        #2;
        check("queue_drained", exp_q.size()[15:0], 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
